// File: rtl/read_pattern_pkg.sv
// Shared geometry and FSM encoding for the pattern reader and the pattern-draw writer.
package read_pattern_pkg;

    localparam int MAX_X  = 64;
    localparam int MAX_Y  = 48;
    localparam int CELLS  = MAX_X * MAX_Y;
    localparam int WIN    = 8;
    localparam int PAT_W  = WIN * WIN;
    localparam int IDX_W  = $clog2(PAT_W);
    localparam int DX_W   = $clog2(WIN);
    localparam int ALV_W  = $clog2(PAT_W + 1);
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CUR_W  = 8;
    // One extra bit so cursor + offset never wraps back onto the board.
    localparam int NXY_W  = CUR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } rp_state_e;

endpackage

// File: rtl/read_pattern_cell_addr.sv
// Maps a window index to a board cell index and flags cells that fall off the board.
// Shared with the writer so both agree on window geometry and clipping.
module pattern_cell_addr
    import read_pattern_pkg::*;
(
    input  logic [CUR_W-1:0]  cur_x,
    input  logic [CUR_W-1:0]  cur_y,
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    logic [NXY_W-1:0] nx;
    logic [NXY_W-1:0] ny;

    assign nx    = NXY_W'(cur_x) + NXY_W'(idx[DX_W-1:0]);
    assign ny    = NXY_W'(cur_y) + NXY_W'(idx[IDX_W-1:DX_W]);
    assign valid = (nx < NXY_W'(MAX_X)) && (ny < NXY_W'(MAX_Y));
    // Truncation to ADDR_W is safe: the product is only used when the cell is on the board.
    assign addr  = valid ? (ADDR_W'(ny) * ADDR_W'(MAX_X) + ADDR_W'(nx)) : '0;

endmodule

// File: rtl/read_pattern.sv
// Captures the 8x8 board window at the cursor, one cell per clock, into a pattern
// matrix plus live-cell count.
module read_pattern
    import read_pattern_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CUR_W-1:0] cursor_x,
    input  logic [CUR_W-1:0] cursor_y,
    input  logic [CELLS-1:0] state,
    output logic             busy,
    output logic             done,
    output logic [PAT_W-1:0] pattern_mat,
    output logic [ALV_W-1:0] alives
);

    rp_state_e          st_q, st_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CUR_W-1:0]   cx_q, cx_d;
    logic [CUR_W-1:0]   cy_q, cy_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [ALV_W-1:0]   alv_q, alv_d;
    logic [ADDR_W-1:0]  cell_addr;
    logic               cell_valid;
    logic               cell_bit;
    logic               accept;

    pattern_cell_addr u_addr (
        .cur_x (cx_q),
        .cur_y (cy_q),
        .idx   (idx_q),
        .addr  (cell_addr),
        .valid (cell_valid)
    );

    // Off-board cells read as dead without indexing the board.
    assign cell_bit = cell_valid & state[cell_addr];
    // DONE accepts a new start just like IDLE, so captures can run back to back.
    assign accept   = start && ((st_q == ST_IDLE) || (st_q == ST_DONE));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= ST_IDLE;
        else        st_q <= st_d;
    end

    // Next-state logic: scan runs exactly PAT_W cycles, DONE lasts one cycle.
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE, ST_DONE: st_d = start ? ST_SCAN : ST_IDLE;
            ST_SCAN:          if (idx_q == IDX_W'(PAT_W - 1)) st_d = ST_DONE;
            default:          st_d = ST_IDLE;
        endcase
    end

    // Outputs decoded directly from the state.
    always_comb begin
        busy = (st_q == ST_SCAN);
        done = (st_q == ST_DONE);
    end

    // Datapath registers: latched cursor, scan index, captured pattern and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            cx_q  <= '0;
            cy_q  <= '0;
            pat_q <= '0;
            alv_q <= '0;
        end else begin
            idx_q <= idx_d;
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            pat_q <= pat_d;
            alv_q <= alv_d;
        end
    end

    // Latch and clear on an accepted start; sample one cell per SCAN cycle; otherwise hold.
    always_comb begin
        idx_d = idx_q;
        cx_d  = cx_q;
        cy_d  = cy_q;
        pat_d = pat_q;
        alv_d = alv_q;
        if (accept) begin
            cx_d  = cursor_x;
            cy_d  = cursor_y;
            idx_d = '0;
            pat_d = '0;
            alv_d = '0;
        end else if (st_q == ST_SCAN) begin
            pat_d[idx_q] = cell_bit;
            alv_d        = alv_q + ALV_W'(cell_bit);
            idx_d        = idx_q + IDX_W'(1);
        end
    end

    assign pattern_mat = pat_q;
    assign alives      = alv_q;

endmodule

// File: tb/tb_read_pattern.sv
// Scoreboard bench for read_pattern: expected windows are queued at start and
// compared when done pulses.
module tb_read_pattern;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    cursor_x;
    logic [7:0]    cursor_y;
    logic [3071:0] state;
    logic          busy;
    logic          done;
    logic [63:0]   pattern_mat;
    logic [6:0]    alives;

    typedef struct packed {
        logic [63:0] pat;
        logic [6:0]  alv;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   passes;

    read_pattern dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .state       (state),
        .busy        (busy),
        .done        (done),
        .pattern_mat (pattern_mat),
        .alives      (alives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference window extraction from the board, straight from the cell geometry.
    function automatic exp_t model(input int x, input int y, input logic [3071:0] b);
        exp_t e;
        e.pat = '0;
        e.alv = '0;
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++)
                if ((x + dx) < 64 && (y + dy) < 48 && b[(y + dy) * 64 + (x + dx)]) begin
                    e.pat[dy * 8 + dx] = 1'b1;
                    e.alv = e.alv + 7'd1;
                end
        return e;
    endfunction

    // Pulse start for one edge, then count cycles until done (bounded).
    task automatic run_capture(input logic [7:0] x, input logic [7:0] y,
                               output int lat, output int bcnt);
        @(negedge clk);
        cursor_x = x;
        cursor_y = y;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cursor_x = 8'($urandom);
        cursor_y = 8'($urandom);
        lat  = -1;
        bcnt = 0;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cursor_x = 8'd0;
        cursor_y = 8'd0;
        state = '0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_ctrl busy/done=%b expected 00", {busy, done}); else passes++;
        checks++; if (pattern_mat !== 64'd0) $display("FAIL reset_pat got %h expected 0", pattern_mat); else passes++;
        checks++; if (alives !== 7'd0) $display("FAIL reset_alv got %0d expected 0", alives); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_glider();
        int lat, bcnt;
        exp_t e;
        state = '0;
        state[0 * 64 + 1] = 1'b1;
        state[1 * 64 + 2] = 1'b1;
        state[2 * 64 + 0] = 1'b1;
        state[2 * 64 + 1] = 1'b1;
        state[2 * 64 + 2] = 1'b1;
        sb.push_back('{pat: 64'h0000000000070402, alv: 7'd5});
        run_capture(8'd0, 8'd0, lat, bcnt);
        checks++; if (lat !== 64) $display("FAIL glider_latency got %0d expected 64", lat); else passes++;
        checks++; if (bcnt !== 64) $display("FAIL glider_busy_cycles got %0d expected 64", bcnt); else passes++;
        e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat) $display("FAIL glider_pat got %h expected %h", pattern_mat, e.pat); else passes++;
        checks++; if (alives !== e.alv) $display("FAIL glider_alv got %0d expected %0d", alives, e.alv); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL glider_done_width done still %b expected 0", done); else passes++;
        state = '1;
        repeat (5) @(negedge clk);
        checks++; if (pattern_mat !== e.pat || alives !== e.alv) $display("FAIL glider_hold got %h/%0d expected %h/%0d", pattern_mat, alives, e.pat, e.alv); else passes++;
    endtask

    task automatic test_corner_clip();
        int lat, bcnt;
        exp_t e;
        state = '1;
        sb.push_back('{pat: 64'h000000000F0F0F0F, alv: 7'd16});
        run_capture(8'd60, 8'd44, lat, bcnt);
        checks++; if (lat !== 64) $display("FAIL corner_latency got %0d expected 64", lat); else passes++;
        e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat) $display("FAIL corner_pat got %h expected %h", pattern_mat, e.pat); else passes++;
        checks++; if (alives !== e.alv) $display("FAIL corner_alv got %0d expected %0d", alives, e.alv); else passes++;
    endtask

    task automatic test_off_board();
        int lat, bcnt;
        exp_t e;
        state = '1;
        sb.push_back('{pat: 64'd0, alv: 7'd0});
        run_capture(8'd200, 8'd0, lat, bcnt);
        checks++; if (lat !== 64) $display("FAIL offboard_latency got %0d expected 64", lat); else passes++;
        e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat || alives !== e.alv) $display("FAIL offboard_out got %h/%0d expected %h/%0d", pattern_mat, alives, e.pat, e.alv); else passes++;
    endtask

    task automatic test_full_window();
        int lat, bcnt;
        exp_t e;
        state = '1;
        sb.push_back('{pat: '1, alv: 7'b1000000});
        run_capture(8'd10, 8'd10, lat, bcnt);
        e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat) $display("FAIL full_pat got %h expected %h", pattern_mat, e.pat); else passes++;
        checks++; if (alives !== e.alv) $display("FAIL full_alv got %0d expected %0d", alives, e.alv); else passes++;
    endtask

    task automatic test_random_edge();
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 96; i++) state[i * 32 +: 32] = $urandom;
        sb.push_back(model(58, 42, state));
        run_capture(8'd58, 8'd42, lat, bcnt);
        e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat || alives !== e.alv) $display("FAIL random_edge got %h/%0d expected %h/%0d", pattern_mat, alives, e.pat, e.alv); else passes++;
    endtask

    task automatic test_back_to_back();
        int first, second, ndone;
        exp_t e;
        for (int i = 0; i < 96; i++) state[i * 32 +: 32] = $urandom;
        sb.push_back(model(3, 5, state));
        @(negedge clk);
        cursor_x = 8'd3;
        cursor_y = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first = -1;
        second = -1;
        ndone = 0;
        for (int n = 0; n < 300; n++) begin
            start    = (n == 5 || n == 30) ? 1'b1 : 1'b0;
            cursor_x = (n == 5 || n == 30) ? 8'd40 : cursor_x;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = n;
                    e = sb.pop_front();
                    checks++; if (pattern_mat !== e.pat || alives !== e.alv) $display("FAIL b2b_first got %h/%0d expected %h/%0d", pattern_mat, alives, e.pat, e.alv); else passes++;
                    cursor_x = 8'd20;
                    cursor_y = 8'd30;
                    start    = 1'b1;
                    sb.push_back(model(20, 30, state));
                end else begin
                    second = n;
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (first !== 64) $display("FAIL b2b_ignore_start first done at %0d expected 64", first); else passes++;
        checks++; if (second !== first + 65) $display("FAIL b2b_second done at %0d expected %0d", second, first + 65); else passes++;
        checks++; if (ndone !== 2) $display("FAIL b2b_done_count got %0d expected 2", ndone); else passes++;
        if (sb.size() > 0) e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat || alives !== e.alv) $display("FAIL b2b_second_out got %h/%0d expected %h/%0d", pattern_mat, alives, e.pat, e.alv); else passes++;
    endtask

    task automatic test_reset_mid_scan();
        int lat, bcnt, ndone;
        exp_t e;
        state = '1;
        @(negedge clk);
        cursor_x = 8'd10;
        cursor_y = 8'd10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL midrst_ctrl busy/done=%b expected 00", {busy, done}); else passes++;
        checks++; if (pattern_mat !== 64'd0 || alives !== 7'd0) $display("FAIL midrst_out got %h/%0d expected 0/0", pattern_mat, alives); else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 80; n++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone !== 0) $display("FAIL midrst_no_done saw %0d busy/done cycles expected 0", ndone); else passes++;
        checks++; if (pattern_mat !== 64'd0 || alives !== 7'd0) $display("FAIL midrst_hold got %h/%0d expected 0/0", pattern_mat, alives); else passes++;
        state = '0;
        state[0 * 64 + 1] = 1'b1;
        state[1 * 64 + 2] = 1'b1;
        state[2 * 64 + 0] = 1'b1;
        state[2 * 64 + 1] = 1'b1;
        state[2 * 64 + 2] = 1'b1;
        sb.push_back('{pat: 64'h0000000000070402, alv: 7'd5});
        run_capture(8'd0, 8'd0, lat, bcnt);
        checks++; if (lat !== 64) $display("FAIL midrst_fresh_latency got %0d expected 64", lat); else passes++;
        e = sb.pop_front();
        checks++; if (pattern_mat !== e.pat || alives !== e.alv) $display("FAIL midrst_fresh_out got %h/%0d expected %h/%0d", pattern_mat, alives, e.pat, e.alv); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_glider();
        test_corner_clip();
        test_off_board();
        test_full_window();
        test_random_edge();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
